// File: rtl/cpu_inst_types.sv
// Instruction-side shared types.
// Holds the instruction word width used by the fetch path of the memory
// port arbiter and by other instruction-side blocks.
package cpu_inst_types;

   localparam int INST_W = 16;

   typedef logic [INST_W-1:0] inst_word_t;

endpackage

// File: rtl/cpu_mem_types.sv
// Memory-side shared types.
// State encoding for the memory port arbiter FSM, the requester id used by
// the round-robin tie-break, and the bus widths of the shared memory port.
package cpu_mem_types;

   localparam int ADDR_W  = 32;
   localparam int WORD_W  = 32;
   localparam int DWIDE_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_DONE = 2'd3
   } arb_state_t;

   // Bit position of each requester in the arbiter request/grant vectors.
   typedef enum logic {
      REQ_FETCH = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   req[1:0]    - requests, bit index = req_id_t (0 fetch, 1 data)
//   en          - a grant is being taken this cycle; advances the pointer
//   gnt[1:0]    - one-hot grant (combinational)
// The pointer remembers the last granted requester; on a tie the other one
// wins. Reset points at fetch so the data unit wins the first tie.
module rr_arbiter2
   import cpu_mem_types::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   req_id_t last_q;

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11)
         gnt = (last_q == REQ_FETCH) ? 2'b10 : 2'b01;
      else
         gnt = req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_q <= REQ_FETCH;
      else if (en && (gnt != 2'b00))
         last_q <= gnt[1] ? REQ_DATA : REQ_FETCH;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit word-addressed memory port between the instruction fetch
// unit (narrow reads) and the data unit (1- or 2-word reads and writes).
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   f_req/f_addr -> f_gnt/f_rdy/f_data          - fetch requester
//   d_req/d_we/d_wide/d_addr/d_wdata
//              -> d_gnt/d_rdy/d_rdata           - data requester
//   mem_addr/mem_wdata/mem_we, mem_rdata        - memory port; read data
//                                                 returns one cycle after
//                                                 the address
//   busy                            - high whenever the FSM is not IDLE
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no access; grant a requester combinationally and latch request
// ACC0    | first beat on the memory port (addr, low write word)
// ACC1    | second beat of a wide access (addr+1, high write word);
//         | captures the first read word
// DONE    | captures the last read word, updates outputs, pulses rdy next
module mem_port_arbiter
   import cpu_mem_types::*;
   import cpu_inst_types::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                f_req,
   input  logic [ADDR_W-1:0]   f_addr,
   output logic                f_gnt,
   output logic                f_rdy,
   output logic [INST_W-1:0]   f_data,
   input  logic                d_req,
   input  logic                d_we,
   input  logic                d_wide,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DWIDE_W-1:0]  d_wdata,
   output logic                d_gnt,
   output logic                d_rdy,
   output logic [DWIDE_W-1:0]  d_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [WORD_W-1:0]   mem_wdata,
   output logic                mem_we,
   input  logic [WORD_W-1:0]   mem_rdata,
   output logic                busy
);

   arb_state_t          state;
   req_id_t             who_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic                wide_q;
   logic [DWIDE_W-1:0]  wdata_q;
   logic [WORD_W-1:0]   word_lo;

   logic       idle;
   logic       arb_en;
   logic [1:0] arb_req;
   logic [1:0] arb_gnt;

   assign idle    = (state == ST_IDLE);
   assign arb_req = {d_req, f_req};
   assign arb_en  = idle & (|arb_req);

   rr_arbiter2 u_rr (
      .clk   (clk),
      .reset (reset),
      .req   (arb_req),
      .en    (arb_en),
      .gnt   (arb_gnt)
   );

   // Reset is folded in so no grant escapes while state is being cleared.
   assign f_gnt = idle & ~reset & arb_gnt[REQ_FETCH];
   assign d_gnt = idle & ~reset & arb_gnt[REQ_DATA];
   assign busy  = ~idle;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         who_q     <= REQ_FETCH;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wide_q    <= 1'b0;
         wdata_q   <= '0;
         word_lo   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         f_rdy     <= 1'b0;
         f_data    <= '0;
         d_rdy     <= 1'b0;
         d_rdata   <= '0;
      end else begin
         f_rdy <= 1'b0;
         d_rdy <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_en) begin
                  // Memory port is loaded at the grant edge so ACC0 drives it
                  // straight from registers.
                  if (arb_gnt[REQ_DATA]) begin
                     who_q     <= REQ_DATA;
                     addr_q    <= d_addr;
                     we_q      <= d_we;
                     wide_q    <= d_wide;
                     wdata_q   <= d_wdata;
                     mem_addr  <= d_addr;
                     mem_we    <= d_we;
                     mem_wdata <= d_wdata[WORD_W-1:0];
                  end else begin
                     who_q     <= REQ_FETCH;
                     addr_q    <= f_addr;
                     we_q      <= 1'b0;
                     wide_q    <= 1'b0;
                     wdata_q   <= '0;
                     mem_addr  <= f_addr;
                     mem_we    <= 1'b0;
                     mem_wdata <= '0;
                  end
                  state <= ST_ACC0;
               end
            end
            ST_ACC0: begin
               if (wide_q) begin
                  mem_addr  <= addr_q + 32'd1;
                  mem_we    <= we_q;
                  mem_wdata <= wdata_q[DWIDE_W-1:WORD_W];
                  state     <= ST_ACC1;
               end else begin
                  mem_we <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            ST_ACC1: begin
               word_lo <= mem_rdata;
               mem_we  <= 1'b0;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               // Last-beat word goes straight into the requester output so
               // data and rdy appear together.
               mem_addr  <= '0;
               mem_wdata <= '0;
               mem_we    <= 1'b0;
               state     <= ST_IDLE;
               if (who_q == REQ_FETCH) begin
                  f_rdy  <= 1'b1;
                  f_data <= mem_rdata[INST_W-1:0];
               end else begin
                  d_rdy <= 1'b1;
                  if (!we_q)
                     d_rdata <= wide_q ? {mem_rdata, word_lo} : {32'h0, mem_rdata};
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   typedef struct {
      logic [63:0] data;
      int          due;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_rdy;
   logic [15:0] f_data;
   logic        d_req;
   logic        d_we;
   logic        d_wide;
   logic [31:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_gnt;
   logic        d_rdy;
   logic [63:0] d_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   exp_t        f_q[$];
   exp_t        d_q[$];
   logic [63:0] d_last_exp = 64'h0;
   bit          tb_last = 1'b0;   // 0: fetch granted last, 1: data

   mem_port_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_gnt     (f_gnt),
      .f_rdy     (f_rdy),
      .f_data    (f_data),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_wide    (d_wide),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rdy     (d_rdy),
      .d_rdata   (d_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Memory: read data is valid the cycle after the address.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   task automatic mem_init(input logic [31:0] a, input logic [31:0] v);
      mem[a] = v;
      ref_mem[a] = v;
   endtask

   // Monitor: grant rule model and rdy scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      logic ef, ed;
      if (reset) begin
         tb_last = 1'b0;
      end else begin
         ef = 1'b0;
         ed = 1'b0;
         if (!busy) begin
            if (f_req && d_req) begin
               ed = ~tb_last;
               ef = tb_last;
            end else begin
               ef = f_req;
               ed = d_req;
            end
            if (ef) tb_last = 1'b0;
            if (ed) tb_last = 1'b1;
            chk("mem_we_idle", mem_we, 0);
            chk("mem_addr_idle", mem_addr, 0);
            chk("mem_wdata_idle", mem_wdata, 0);
         end
         chk("grant", {f_gnt, d_gnt}, {ef, ed});
         if (f_q.size() > 0 && f_q[0].due == cyc) begin
            e = f_q.pop_front();
            chk("f_rdy", f_rdy, 1);
            chk("f_data", f_data, e.data);
         end else
            chk("f_rdy_quiet", f_rdy, 0);
         if (d_q.size() > 0 && d_q[0].due == cyc) begin
            e = d_q.pop_front();
            chk("d_rdy", d_rdy, 1);
            chk("d_rdata", d_rdata, e.data);
         end else
            chk("d_rdy_quiet", d_rdy, 0);
      end
   end

   task automatic f_issue(input logic [31:0] a);
      exp_t e;
      logic [31:0] w;
      int n;
      @(posedge clk); #1;
      w = ref_rd(a);
      f_addr = a;
      f_req  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!f_gnt && n < 100);
      chk("f_gnt_wait", f_gnt, 1);
      if (f_gnt) begin
         e.data = {48'h0, w[15:0]};
         e.due  = cyc + 3;
         f_q.push_back(e);
      end
      @(posedge clk); #1;
      f_req = 1'b0;
   endtask

   task automatic d_issue(input logic we, input logic wide, input logic [31:0] a,
                          input logic [63:0] wd, input bit push);
      exp_t e;
      logic [31:0] a1, lo, hi;
      int n;
      @(posedge clk); #1;
      a1 = a + 32'd1;
      lo = ref_rd(a);
      hi = ref_rd(a1);
      if (we) e.data = d_last_exp;
      else    e.data = wide ? {hi, lo} : {32'h0, lo};
      d_addr  = a;
      d_we    = we;
      d_wide  = wide;
      d_wdata = wd;
      d_req   = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!d_gnt && n < 100);
      chk("d_gnt_wait", d_gnt, 1);
      if (d_gnt && push) begin
         e.due = cyc + (wide ? 4 : 3);
         d_q.push_back(e);
         if (we) begin
            ref_mem[a] = wd[31:0];
            if (wide) ref_mem[a1] = wd[63:32];
         end else
            d_last_exp = e.data;
      end
      @(posedge clk); #1;
      d_req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((f_q.size() > 0 || d_q.size() > 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      exp_t e;
      int n;
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int n;
      reset   = 1'b1;
      f_req   = 1'b1;
      f_addr  = 32'h10;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_wide  = 1'b0;
      d_addr  = 32'h20;
      d_wdata = 64'h0;
      mem_init(32'h10, 32'h0000ABCD);
      mem_init(32'h20, 32'h11111111);
      mem_init(32'h21, 32'h22222222);
      for (int i = 0; i < 64; i++) begin
         mem_init(32'h100 + i, $urandom);
         mem_init(32'h40 + i, $urandom);
      end

      // Reset state with both requests already high.
      repeat (2) @(negedge clk);
      chk("rst_f_gnt", f_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_f_rdy", f_rdy, 0);
      chk("rst_d_rdy", d_rdy, 0);
      chk("rst_f_data", f_data, 0);
      chk("rst_d_rdata", d_rdata, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Requests held from reset: data, fetch, data, fetch, ...
      for (int k = 0; k < 6; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!f_gnt && !d_gnt && n < 20);
         chk("rr_alt_d", d_gnt, (k % 2 == 0));
         chk("rr_alt_f", f_gnt, (k % 2 == 1));
         if (d_gnt) begin
            e.data = {32'h0, ref_rd(32'h20)};
            e.due  = cyc + 3;
            d_q.push_back(e);
            d_last_exp = e.data;
         end
         if (f_gnt) begin
            e.data = 64'h0000_0000_0000_ABCD;
            e.due  = cyc + 3;
            f_q.push_back(e);
         end
      end
      @(posedge clk); #1;
      f_req = 1'b0;
      d_req = 1'b0;
      drain();

      // Narrow fetch of 0x10.
      f_issue(32'h10);
      @(negedge clk);
      chk("f_mem_addr", mem_addr, 32'h10);
      chk("f_mem_we", mem_we, 0);
      drain();

      // Wide read of 0x20/0x21.
      d_issue(1'b0, 1'b1, 32'h20, 64'h0, 1'b1);
      @(negedge clk);
      chk("wr_addr0", mem_addr, 32'h20);
      @(negedge clk);
      chk("wr_addr1", mem_addr, 32'h21);
      drain();

      // Wide write wrapping past the top of the address space.
      d_issue(1'b1, 1'b1, 32'hFFFF_FFFF, 64'hCAFEBABE_DEADBEEF, 1'b1);
      @(negedge clk);
      chk("ww_we0", mem_we, 1);
      chk("ww_addr0", mem_addr, 32'hFFFF_FFFF);
      chk("ww_data0", mem_wdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("ww_we1", mem_we, 1);
      chk("ww_addr1", mem_addr, 32'h0);
      chk("ww_data1", mem_wdata, 32'hCAFEBABE);
      @(negedge clk);
      chk("ww_we_done", mem_we, 0);
      drain();
      d_issue(1'b0, 1'b1, 32'hFFFF_FFFF, 64'h0, 1'b1);
      drain();

      // New fetch request in the d_rdy cycle is granted at once.
      d_issue(1'b0, 1'b0, 32'h20, 64'h0, 1'b1);
      @(posedge clk);
      @(posedge clk); #1;
      f_addr = 32'h10;
      f_req  = 1'b1;
      @(negedge clk);
      chk("b2b_d_rdy", d_rdy, 1);
      chk("b2b_f_gnt", f_gnt, 1);
      chk("b2b_busy_low", busy, 0);
      if (f_gnt) begin
         e.data = 64'h0000_0000_0000_ABCD;
         e.due  = cyc + 3;
         f_q.push_back(e);
      end
      @(posedge clk); #1;
      f_req = 1'b0;
      @(negedge clk);
      chk("b2b_busy_high", busy, 1);
      drain();

      // Reset during ACC1 of a wide read.
      d_issue(1'b0, 1'b1, 32'h20, 64'h0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_mem_we", mem_we, 0);
      chk("abort_mem_addr", mem_addr, 0);
      chk("abort_d_rdy", d_rdy, 0);
      chk("abort_d_rdata", d_rdata, 0);
      chk("abort_f_data", f_data, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      d_last_exp = 64'h0;
      repeat (6) @(negedge clk);
      chk("abort_d_rdata_hold", d_rdata, 0);
      chk("abort_idle", busy, 0);

      // Random concurrent traffic; fetch region never written by data unit.
      fork
         begin
            logic [31:0] fa;
            for (int i = 0; i < 20; i++) begin
               fa = 32'h100 + ($urandom % 64);
               f_issue(fa);
               repeat ($urandom % 3) @(posedge clk);
            end
         end
         begin
            logic        rwe, rwide;
            logic [31:0] ra;
            logic [63:0] rwd;
            for (int i = 0; i < 30; i++) begin
               rwe   = 1'($urandom_range(0, 1));
               rwide = 1'($urandom_range(0, 1));
               ra    = 32'h40 + ($urandom % 64);
               rwd   = {$urandom, $urandom};
               d_issue(rwe, rwide, ra, rwd, 1'b1);
               repeat ($urandom % 3) @(posedge clk);
            end
         end
      join
      drain();
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
